// File: rtl/fst_io_pkg.sv
// Shared types and widths for the fst I/O blocks.
// Used by the output UART and its FIFO.
package fst_io_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/out_uart_if.sv
// Core-to-UART write strobe bundle.
// The core drives it; the UART only listens, never stalls.
interface out_uart_if;
  import fst_io_pkg::*;

  logic              out_en;
  logic [WORD_W-1:0] out_dat;

  modport master (
    output out_en,
    output out_dat
  );

  modport slave (
    input out_en,
    input out_dat
  );

endinterface

// File: rtl/out_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Extra pointer MSB separates full from empty.
module out_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                wr_en;
  logic                rd_en;

  assign full =
    (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/out_uart.sv
// Output-port UART: buffers 16-bit words from the core and
// sends each as two 8N1 bytes, high byte first.
module out_uart
  import fst_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  out_uart_if.slave           core,
  output logic                tx,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                overflow
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [WORD_W-1:0] word;
  logic              byte_sel;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        nxt_idx;
  logic [BYTE_W-1:0] cur_byte;
  logic              bit_last;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;
  logic              pop;

  assign pop      = (state == IDLE) && !fifo_empty;
  assign cur_byte = byte_sel ? word[BYTE_W-1:0]
                             : word[WORD_W-1:BYTE_W];
  assign bit_last = (bit_cnt == CNT_LAST);
  assign nxt_idx  = bit_idx + 3'd1;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  out_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (core.out_en),
    .din     (core.out_dat),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // tx is updated on the same edge as each state change,
  // so the line shows each new bit right after that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      word     <= '0;
      byte_sel <= 1'b0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      if (core.out_en && fifo_full)
        overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            word     <= fifo_dout;
            byte_sel <= 1'b0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= nxt_idx;
              tx      <= cur_byte[nxt_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart with short bit time
// and a 4-word FIFO.
module tb_out_uart;
  import fst_io_pkg::*;

  localparam int C     = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int FRAME = 20 * C;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           tx;
  logic           busy;
  logic [DL2:0]   fifo_count;
  logic           overflow;

  out_uart_if bus ();

  int checks = 0;
  int errors = 0;

  out_uart #(
    .CLKS_PER_BIT (C),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core       (bus.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles into a word's frame.
  function automatic logic frame_bit(
    input logic [15:0] w, input int k);
    int bi  = k / (10 * C);
    int pos = (k % (10 * C)) / C;
    logic [7:0] b = (bi == 0) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Abstract FIFO model for n writes on consecutive edges
  // into an idle block: the first buffered word leaves for
  // the transmitter on the next edge, capacity is DEPTH.
  logic [15:0] words [8];
  logic [15:0] exp_q [$];
  int          mdl_buf;
  bit          mdl_drop;

  task automatic model_seq(input int n);
    int  b = 0;
    bit  sending = 0;
    bit  p, ok;
    exp_q.delete();
    mdl_drop = 0;
    for (int i = 0; i < n; i++) begin
      p  = !sending && b > 0;
      ok = b < DEPTH;
      b  = b - int'(p) + int'(ok);
      if (p) sending = 1;
      if (ok) exp_q.push_back(words[i]);
      else mdl_drop = 1;
    end
    mdl_buf = b;
  endtask

  task automatic recv_word(
    output logic [15:0] w, output bit ok);
    logic [7:0] b;
    int t;
    ok = 1;
    w  = '0;
    b  = '0;
    for (int n = 0; n < 2; n++) begin
      t = 0;
      while (tx !== 1'b0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) begin
        ok = 0;
        return;
      end
      repeat (C + C / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = tx;
        repeat (C) @(negedge clk);
      end
      if (tx !== 1'b1) ok = 0;
      if (n == 0) w[15:8] = b;
      else w[7:0] = b;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, need 0",
               busy, t);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.out_en  = 1'b0;
    bus.out_dat = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx, busy, fifo_count, overflow} !==
        {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b cnt=%0d ovf=%b",
               tx, busy, fifo_count, overflow);
    end
  endtask

  task automatic test_frame();
    logic [15:0] w = 16'hA55A;
    int bad = 0;
    bus.out_en  = 1'b1;
    bus.out_dat = w;
    @(negedge clk);
    bus.out_en = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_n: cnt=%0d tx=%b busy=%b, need 1 1 1",
               fifo_count, tx, busy);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: cnt=%0d tx=%b, need 0 0",
               fifo_count, tx);
    end
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx !== frame_bit(w, k)) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL frame_a55a k=%0d: tx=%b need %b",
                   k, tx, frame_bit(w, k));
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL frame_end: busy=%b tx=%b, need 0 1",
               busy, tx);
    end
  endtask

  task automatic test_random();
    int n = 3;
    for (int i = 0; i < n; i++)
      words[i] = 16'($urandom);
    model_seq(n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bus.out_en  = 1'b1;
          bus.out_dat = words[i];
          @(negedge clk);
        end
        bus.out_en = 1'b0;
        checks++;
        if (fifo_count !== 3'(mdl_buf)) begin
          errors++;
          $display("FAIL rand_count: cnt=%0d need %0d",
                   fifo_count, mdl_buf);
        end
      end
      begin
        logic [15:0] got;
        bit ok;
        for (int m = 0; m < exp_q.size(); m++) begin
          recv_word(got, ok);
          checks++;
          if (!ok || got !== exp_q[m]) begin
            errors++;
            $display("FAIL rand_word%0d: got %h ok=%b need %h",
                     m, got, ok, exp_q[m]);
          end
        end
      end
    join
    wait_idle();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rand_ovf: ovf=%b need 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w0 = 16'h0001;
    logic [15:0] w1 = 16'hFFFF;
    logic e;
    int bad = 0;
    bus.out_en  = 1'b1;
    bus.out_dat = w0;
    @(negedge clk);
    bus.out_dat = w1;
    @(negedge clk);
    bus.out_en = 1'b0;
    for (int k = 0; k < 2 * FRAME + 1; k++) begin
      if (k < FRAME) e = frame_bit(w0, k);
      else if (k == FRAME) e = 1'b1;
      else e = frame_bit(w1, k - FRAME - 1);
      checks++;
      if (tx !== e) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL b2b k=%0d: tx=%b need %b", k, tx, e);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b need 0", busy);
    end
  endtask

  task automatic test_overflow();
    int n = 6;
    for (int i = 0; i < n; i++)
      words[i] = 16'($urandom);
    model_seq(n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bus.out_en  = 1'b1;
          bus.out_dat = words[i];
          @(negedge clk);
        end
        bus.out_en = 1'b0;
        checks++;
        if (overflow !== mdl_drop ||
            fifo_count !== 3'(mdl_buf)) begin
          errors++;
          $display("FAIL ovf_set: ovf=%b cnt=%0d need %b %0d",
                   overflow, fifo_count, mdl_drop, mdl_buf);
        end
      end
      begin
        logic [15:0] got;
        bit ok;
        for (int m = 0; m < exp_q.size(); m++) begin
          recv_word(got, ok);
          checks++;
          if (!ok || got !== exp_q[m]) begin
            errors++;
            $display("FAIL ovf_word%0d: got %h ok=%b need %h",
                     m, got, ok, exp_q[m]);
          end
        end
      end
    join
    wait_idle();
    begin
      bit low = 0;
      repeat (200) begin
        if (tx !== 1'b1) low = 1;
        @(negedge clk);
      end
      checks++;
      if (low || overflow !== 1'b1 || exp_q.size() != 5) begin
        errors++;
        $display("FAIL ovf_after: extra=%b ovf=%b words=%0d need 0 1 5",
                 low, overflow, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_en  = 1'b1;
    bus.out_dat = 16'h0000;
    @(negedge clk);
    bus.out_en = 1'b0;
    repeat (C + 3) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: tx=%b busy=%b need 0 1", tx, busy);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, fifo_count, overflow} !==
        {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b cnt=%0d ovf=%b",
               tx, busy, fifo_count, overflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
    begin
      bit low = 0;
      repeat (3 * FRAME) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) low = 1;
      end
      checks++;
      if (low) begin
        errors++;
        $display("FAIL mid_after: line left idle-high, need 1");
      end
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.out_en  = 1'b1;
      bus.out_dat = 16'(16'h1000 + i);
      @(negedge clk);
    end
    bus.out_en = 1'b0;
    repeat (FRAME - 3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'(DEPTH) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pre: cnt=%0d ovf=%b need %0d 0",
               fifo_count, overflow, DEPTH);
    end
    bus.out_en  = 1'b1;
    bus.out_dat = 16'hDEAD;
    @(negedge clk);
    bus.out_en = 1'b0;
    checks++;
    if (fifo_count !== 3'(DEPTH - 1) || overflow !== 1'b1 ||
        tx !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: cnt=%0d ovf=%b tx=%b need %0d 1 0",
               fifo_count, overflow, tx, DEPTH - 1);
    end
    wait_idle();
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.out_en  = 1'b0;
    bus.out_dat = '0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_random();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
